// File: rtl/hazard3_bus_arb2_if.sv
// Signal bundle joining the fetch frontend, the LSU, the two-master arbiter and the AHB-Lite manager port.
// slave: the arbiter's view. master: the view of the requesters and the system bus.
interface hazard3_bus_arb2_if;
  logic [31:0] f_addr;
  logic        f_size;
  logic        f_priv;
  logic        f_addr_vld;
  logic        f_addr_rdy;
  logic [31:0] f_data;
  logic        f_data_err;
  logic        f_data_vld;

  logic [31:0] l_addr;
  logic [1:0]  l_size;
  logic        l_write;
  logic        l_priv;
  logic        l_addr_vld;
  logic        l_addr_rdy;
  logic [31:0] l_wdata;
  logic [31:0] l_rdata;
  logic        l_data_err;
  logic        l_data_vld;

  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic        hready;
  logic        hresp;
  logic [31:0] hwdata;
  logic [31:0] hrdata;

  modport slave (
    input  f_addr, f_size, f_priv, f_addr_vld,
    output f_addr_rdy, f_data, f_data_err, f_data_vld,
    input  l_addr, l_size, l_write, l_priv, l_addr_vld, l_wdata,
    output l_addr_rdy, l_rdata, l_data_err, l_data_vld,
    output haddr, htrans, hwrite, hsize, hprot, hwdata,
    input  hready, hresp, hrdata
  );

  modport master (
    output f_addr, f_size, f_priv, f_addr_vld,
    input  f_addr_rdy, f_data, f_data_err, f_data_vld,
    output l_addr, l_size, l_write, l_priv, l_addr_vld, l_wdata,
    input  l_addr_rdy, l_rdata, l_data_err, l_data_vld,
    input  haddr, htrans, hwrite, hsize, hprot, hwdata,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/hazard3_bus_arb2.sv
// Two-master AHB-Lite arbiter (fetch + LSU): locked address phase, tracked data-phase owner, response routing.
// Define HAZARD3_ARB_FAIRNESS_EN to force a fetch grant after FETCH_STARVE_LIMIT contested LSU wins.
module hazard3_bus_arb2 #(
  parameter int FETCH_STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  hazard3_bus_arb2_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LSU   = 2'd2
  } owner_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [3:0] STARVE_LIM    = 4'(FETCH_STARVE_LIMIT);

  owner_e aph_owner_q, aph_owner_d;
  owner_e bus_owner;
  owner_e dph_owner_q, dph_owner_d;
  logic   aph_lock_q, aph_lock_d;
  logic   force_fetch;
  logic   err_first;
  logic   f_grant;
  logic   l_grant;

  function automatic logic [2:0] fetch_hsize(input logic size_word);
    return {1'b0, size_word, ~size_word};
  endfunction

  function automatic logic [3:0] make_hprot(input logic priv, input logic data_acc);
    return {2'b00, priv, data_acc};
  endfunction

  assign err_first = bus.hresp && !bus.hready;

  always_comb begin
    aph_owner_d = OWN_NONE;
    if (aph_lock_q) begin
      aph_owner_d = aph_owner_q;
    end else if (bus.l_addr_vld && !force_fetch) begin
      aph_owner_d = OWN_LSU;
    end else if (bus.f_addr_vld) begin
      aph_owner_d = OWN_FETCH;
    end
  end

  // The first cycle of a two-cycle error response must not carry a new address phase.
  assign bus_owner = err_first ? OWN_NONE : aph_owner_d;

  always_comb begin
    bus.htrans = HTRANS_IDLE;
    bus.haddr  = '0;
    bus.hwrite = 1'b0;
    bus.hsize  = '0;
    bus.hprot  = '0;
    case (bus_owner)
      OWN_FETCH: begin
        bus.htrans = HTRANS_NONSEQ;
        bus.haddr  = bus.f_addr;
        bus.hsize  = fetch_hsize(bus.f_size);
        bus.hprot  = make_hprot(bus.f_priv, 1'b0);
      end
      OWN_LSU: begin
        bus.htrans = HTRANS_NONSEQ;
        bus.haddr  = bus.l_addr;
        bus.hwrite = bus.l_write;
        bus.hsize  = {1'b0, bus.l_size};
        bus.hprot  = make_hprot(bus.l_priv, 1'b1);
      end
      default: ;
    endcase
  end

  assign f_grant        = bus.hready && (aph_owner_d == OWN_FETCH);
  assign l_grant        = bus.hready && (aph_owner_d == OWN_LSU);
  assign bus.f_addr_rdy = f_grant;
  assign bus.l_addr_rdy = l_grant;

  // A presented NONSEQ that stalls keeps its owner so the address stays stable.
  assign aph_lock_d = !bus.hready && (bus_owner != OWN_NONE);

  always_comb begin
    dph_owner_d = dph_owner_q;
    if (bus.hready) begin
      dph_owner_d = bus_owner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aph_owner_q <= OWN_NONE;
      aph_lock_q  <= 1'b0;
      dph_owner_q <= OWN_NONE;
    end else begin
      aph_owner_q <= aph_owner_d;
      aph_lock_q  <= aph_lock_d;
      dph_owner_q <= dph_owner_d;
    end
  end

  assign bus.f_data_vld = bus.hready && (dph_owner_q == OWN_FETCH);
  assign bus.f_data_err = bus.f_data_vld && bus.hresp;
  assign bus.f_data     = bus.hrdata;
  assign bus.l_data_vld = bus.hready && (dph_owner_q == OWN_LSU);
  assign bus.l_data_err = bus.l_data_vld && bus.hresp;
  assign bus.l_rdata    = bus.hrdata;
  assign bus.hwdata     = bus.l_wdata;

`ifdef HAZARD3_ARB_FAIRNESS_EN
  logic [3:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (bus.f_addr_vld && f_grant) begin
      starve_cnt_d = '0;
    end else if (bus.f_addr_vld && bus.l_addr_vld && l_grant && (starve_cnt_q != 4'hf)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign force_fetch = (starve_cnt_q >= STARVE_LIM);
`else
  logic cfg_unused;
  assign cfg_unused  = ^STARVE_LIM;
  assign force_fetch = 1'b0;
`endif

endmodule

// File: tb/tb_hazard3_bus_arb2.sv
// Self-checking bench for hazard3_bus_arb2: directed scenarios plus randomized traffic against a
// transaction-level model (pending-address hold, in-flight data-phase queue, starvation count).
module tb_hazard3_bus_arb2;
  localparam int LIMIT = 4;
`ifdef HAZARD3_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  hazard3_bus_arb2_if bus();

  hazard3_bus_arb2 #(.FETCH_STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner 0=none, 1=fetch, 2=LSU
  int  dq[$];
  int  held = 0;
  int  starve = 0;
  bit  live = 1'b0;
  bit  prev_rst = 1'b0;
  bit  prev_hready = 1'b0;
  int  prev_bown = 0;
  bit  prev_frdy = 1'b0, prev_lrdy = 1'b0, prev_fvld = 1'b0, prev_lvld = 1'b0;
  bit  pend_after = 1'b0;
  bit  f_acc_s = 1'b0, l_acc_s = 1'b0;

  always @(negedge clk) begin : model
    int own, bown, front;
    bit err1, e_frdy, e_lrdy, e_fvld, e_lvld;
    if (prev_rst) begin
      dq.delete();
      held   = 0;
      starve = 0;
      live   = 1'b1;
    end else if (live) begin
      if (prev_hready) begin
        if (dq.size() > 0) void'(dq.pop_front());
        if (prev_bown != 0) dq.push_back(prev_bown);
      end
      held = (prev_bown != 0 && !prev_hready) ? prev_bown : 0;
      if (prev_fvld && prev_frdy) starve = 0;
      else if (prev_fvld && prev_lvld && prev_lrdy && starve < 15) starve++;
    end

    if (held != 0) own = held;
    else if (bus.l_addr_vld && !(FAIR && starve >= LIMIT)) own = 2;
    else if (bus.f_addr_vld) own = 1;
    else own = 0;
    err1   = bus.hresp && !bus.hready;
    bown   = err1 ? 0 : own;
    front  = (dq.size() > 0) ? dq[0] : 0;
    e_frdy = bus.hready && own == 1;
    e_lrdy = bus.hready && own == 2;
    e_fvld = bus.hready && front == 1;
    e_lvld = bus.hready && front == 2;

    if (live) begin
      chk("htrans", bus.htrans, (bown != 0) ? 2 : 0);
      chk("hwrite", bus.hwrite, (bown == 2) ? bus.l_write : 0);
      chk("hsize", bus.hsize, (bown == 1) ? (bus.f_size ? 2 : 1) : (bown == 2) ? bus.l_size : 0);
      if (bown == 1) begin
        chk("haddr_f", bus.haddr, bus.f_addr);
        chk("hprot_f", bus.hprot, bus.f_priv ? 2 : 0);
      end
      if (bown == 2) begin
        chk("haddr_l", bus.haddr, bus.l_addr);
        chk("hprot_l", bus.hprot, (bus.l_priv ? 2 : 0) + 1);
      end
      chk("f_addr_rdy", bus.f_addr_rdy, e_frdy);
      chk("l_addr_rdy", bus.l_addr_rdy, e_lrdy);
      chk("f_data_vld", bus.f_data_vld, e_fvld);
      chk("l_data_vld", bus.l_data_vld, e_lvld);
      chk("f_data_err", bus.f_data_err, e_fvld && bus.hresp);
      chk("l_data_err", bus.l_data_err, e_lvld && bus.hresp);
      if (e_fvld) chk("f_data", bus.f_data, bus.hrdata);
      if (e_lvld) chk("l_rdata", bus.l_rdata, bus.hrdata);
      chk("hwdata", bus.hwdata, bus.l_wdata);
    end

    prev_rst    = rst;
    prev_hready = bus.hready;
    prev_bown   = bown;
    prev_frdy   = e_frdy;
    prev_lrdy   = e_lrdy;
    prev_fvld   = bus.f_addr_vld;
    prev_lvld   = bus.l_addr_vld;
    pend_after  = !rst && (bus.hready ? (bown != 0) : (dq.size() > 0));
    f_acc_s     = bus.f_addr_vld && bus.f_addr_rdy;
    l_acc_s     = bus.l_addr_vld && bus.l_addr_rdy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  int err_step = 0;

  initial begin
    bus.f_addr = '0; bus.f_size = 1'b1; bus.f_priv = 1'b0; bus.f_addr_vld = 1'b0;
    bus.l_addr = '0; bus.l_size = 2'd2; bus.l_write = 1'b0; bus.l_priv = 1'b0; bus.l_addr_vld = 1'b0;
    bus.l_wdata = '0; bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;
    step(); step();
    rst = 1'b0;
    settle();
    chk("rst_f_vld", bus.f_data_vld, 0);
    chk("rst_l_vld", bus.l_data_vld, 0);
    chk("rst_htrans", bus.htrans, 0);

    // Fetch only, zero-cycle grant
    step();
    bus.f_addr = 32'h40; bus.f_size = 1'b1; bus.f_priv = 1'b1; bus.f_addr_vld = 1'b1;
    settle();
    chk("d1_f_rdy", bus.f_addr_rdy, 1);
    chk("d1_haddr", bus.haddr, 32'h40);
    chk("d1_hsize", bus.hsize, 2);
    chk("d1_hprot0", bus.hprot[0], 0);
    step();
    bus.f_addr_vld = 1'b0; bus.hrdata = 32'h12345678;
    settle();
    chk("d1_f_vld", bus.f_data_vld, 1);
    chk("d1_f_data", bus.f_data, 32'h12345678);

    // Simultaneous fetch and LSU write
    step();
    bus.f_addr = 32'h80; bus.f_priv = 1'b0; bus.f_addr_vld = 1'b1;
    bus.l_addr = 32'h2000; bus.l_write = 1'b1; bus.l_size = 2'd2; bus.l_addr_vld = 1'b1;
    settle();
    chk("d2_l_rdy", bus.l_addr_rdy, 1);
    chk("d2_f_rdy0", bus.f_addr_rdy, 0);
    chk("d2_hwrite", bus.hwrite, 1);
    chk("d2_hprot0", bus.hprot[0], 1);
    step();
    bus.l_addr_vld = 1'b0; bus.l_write = 1'b0; bus.l_wdata = 32'hCAFEF00D;
    settle();
    chk("d2_f_rdy1", bus.f_addr_rdy, 1);
    chk("d2_haddr", bus.haddr, 32'h80);
    chk("d2_hwdata", bus.hwdata, 32'hCAFEF00D);
    step();
    bus.f_addr_vld = 1'b0;
    settle();
    chk("d2_f_vld", bus.f_data_vld, 1);
    chk("d2_l_vld", bus.l_data_vld, 0);
    step();

    // Wait states: fetch locked in while the LSU arrives
    bus.f_addr = 32'h80; bus.f_addr_vld = 1'b1; bus.hready = 1'b0;
    settle();
    chk("d3_haddr0", bus.haddr, 32'h80);
    for (int i = 1; i < 3; i++) begin
      step();
      bus.l_addr = 32'h3000; bus.l_addr_vld = 1'b1;
      settle();
      chk("d3_haddr_ws", bus.haddr, 32'h80);
      chk("d3_l_rdy_ws", bus.l_addr_rdy, 0);
    end
    step();
    bus.hready = 1'b1;
    settle();
    chk("d3_f_rdy", bus.f_addr_rdy, 1);
    chk("d3_l_rdy", bus.l_addr_rdy, 0);
    chk("d3_haddr3", bus.haddr, 32'h80);
    step();
    bus.f_addr_vld = 1'b0;
    settle();
    chk("d3_l_rdy2", bus.l_addr_rdy, 1);
    chk("d3_haddr4", bus.haddr, 32'h3000);
    chk("d3_f_vld", bus.f_data_vld, 1);
    step();
    bus.l_addr_vld = 1'b0;
    settle();
    chk("d3_l_vld", bus.l_data_vld, 1);
    step();

    // Two-cycle error response on an LSU read
    bus.l_addr = 32'h4000; bus.l_write = 1'b0; bus.l_addr_vld = 1'b1;
    settle();
    chk("d4_l_rdy", bus.l_addr_rdy, 1);
    step();
    bus.l_addr_vld = 1'b0; bus.hresp = 1'b1; bus.hready = 1'b0;
    settle();
    chk("d4_htrans", bus.htrans, 0);
    chk("d4_l_vld0", bus.l_data_vld, 0);
    step();
    bus.hready = 1'b1;
    settle();
    chk("d4_l_vld", bus.l_data_vld, 1);
    chk("d4_l_err", bus.l_data_err, 1);
    chk("d4_f_vld", bus.f_data_vld, 0);
    step();
    bus.hresp = 1'b0;

    // Reset with a fetch data phase outstanding
    bus.f_addr = 32'h100; bus.f_addr_vld = 1'b1;
    settle();
    chk("d5_f_rdy", bus.f_addr_rdy, 1);
    step();
    bus.f_addr_vld = 1'b0; bus.hready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; bus.hready = 1'b1;
    settle();
    chk("d5_f_vld", bus.f_data_vld, 0);
    chk("d5_htrans", bus.htrans, 0);
    step();

    // Continuous contention
    bus.f_addr = 32'h200; bus.f_addr_vld = 1'b1;
    bus.l_addr = 32'h5000; bus.l_addr_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("d6_f_grant", bus.f_addr_rdy, (FAIR && i == 4) ? 1 : 0);
      chk("d6_l_grant", bus.l_addr_rdy, (FAIR && i == 4) ? 0 : 1);
      step();
    end
    bus.f_addr_vld = 1'b0; bus.l_addr_vld = 1'b0;
    step(); step();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if (rst) rst = 1'b0;
      else if (err_step == 0 && $urandom_range(0, 599) == 0) rst = 1'b1;
      if (err_step == 1) begin
        bus.hresp = 1'b1; bus.hready = 1'b1; err_step = 0;
      end else if (pend_after && $urandom_range(0, 11) == 0) begin
        bus.hresp = 1'b1; bus.hready = 1'b0; err_step = 1;
      end else begin
        bus.hresp = 1'b0; bus.hready = ($urandom_range(0, 3) != 0);
      end
      if (!bus.f_addr_vld || f_acc_s) begin
        bus.f_addr_vld = ($urandom_range(0, 2) == 0);
        bus.f_addr     = $urandom() & 32'hffff_fffc;
        bus.f_size     = 1'($urandom_range(0, 1));
        bus.f_priv     = 1'($urandom_range(0, 1));
      end
      if (!bus.l_addr_vld || l_acc_s) begin
        bus.l_addr_vld = ($urandom_range(0, 2) == 0);
        bus.l_addr     = $urandom();
        bus.l_size     = 2'($urandom_range(0, 2));
        bus.l_write    = 1'($urandom_range(0, 1));
        bus.l_priv     = 1'($urandom_range(0, 1));
      end
      bus.l_wdata = $urandom();
      bus.hrdata  = $urandom();
      step();
    end
    rst = 1'b0; bus.hresp = 1'b0; bus.hready = 1'b1;
    bus.f_addr_vld = 1'b0; bus.l_addr_vld = 1'b0;
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard3_bus_arb2.md
# hazard3_bus_arb2

Two-master arbiter sharing one AHB-Lite manager port between the instruction fetch frontend and the load/store unit in single-port processor builds. Arbitrates address phases, holds the grant stable across wait states and records the data-phase owner. Routes read data, errors and write data back to the correct requester. Sits between `hazard3_frontend` and the LSU on one side and the system bus on the other.

## Interface
Parameters:
- `FETCH_STARVE_LIMIT`, default 4: consecutive lost contested cycles before fetch is forced to win (only with `HAZARD3_ARB_FAIRNESS_EN`); range 1–15.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous and active-high.
- `f_addr` in 32: fetch address. `f_size` in 1: 1=word, 0=halfword. `f_priv` in 1: machine-mode fetch.
- `f_addr_vld` in 1, `f_addr_rdy` out 1: fetch address handshake.
- `f_data` out 32, `f_data_err` out 1, `f_data_vld` out 1: fetch response.
- `l_addr` in 32, `l_size` in 2 (0/1/2 = byte/half/word), `l_write` in 1, `l_priv` in 1.
- `l_addr_vld` in 1, `l_addr_rdy` out 1: LSU address handshake.
- `l_wdata` in 32: write data, presented by the LSU during the data phase.
- `l_rdata` out 32, `l_data_err` out 1, `l_data_vld` out 1: LSU response.
- `haddr` out 32, `htrans` out 2 (IDLE=00, NONSEQ=10), `hwrite` out 1, `hsize` out 3.
- `hprot` out 4: [0]=data access (1 for LSU), [1]=privileged, [3:2]=0.
- `hready` in 1, `hresp` in 1, `hwdata` out 32, `hrdata` in 32.

## Operation
- Requesters hold `*_addr_vld` and their address fields stable until `*_addr_rdy` is seen.
- Address-phase owner selection, evaluated each cycle:
  - If `aph_lock` is set, keep the previous owner.
  - Otherwise the LSU wins when `l_addr_vld` is high, unless `force_fetch` is set.
  - Otherwise fetch wins when `f_addr_vld` is high.
  - Otherwise no owner.
- Bus output mux:
  - `htrans`=NONSEQ when there is an owner, otherwise IDLE.
  - `haddr`, `hwrite`, `hsize` and `hprot` come from the owner. Fetch drives `hsize`={1'b0,`f_size`,~`f_size`} and `hwrite`=0.
  - `hwrite`/`hsize` are 0 when idle.
- `aph_lock` register:
  - Set when `htrans`=NONSEQ and `hready`=0.
  - Cleared on `hready`=1.
  - Guarantees AHB address stability across wait states.
- Address handshakes: `f_addr_rdy` = `hready` & fetch owns the address phase; `l_addr_rdy` likewise for the LSU.
- `dph_owner` state: NONE, FETCH, LSU. On `hready`=1 it loads the address-phase owner (NONE if idle). It holds otherwise.
- Responses:
  - `f_data_vld` = `hready` & `dph_owner`==FETCH; `f_data_err` = `f_data_vld` & `hresp`; `f_data` = `hrdata`.
  - LSU response is identical with `dph_owner`==LSU.
  - `hwdata` = `l_wdata` unconditionally.
- Error cycle 1 (`hresp`=1, `hready`=0):
  - Drive `htrans`=IDLE and clear `aph_lock` next cycle.
  - The pending requester is not acknowledged and re-presents its request later.

## Timing
- Reset values: `dph_owner`=NONE, `aph_lock`=0, starve counter 0, `force_fetch`=0. All `*_vld` outputs are 0 because `dph_owner`=NONE.
- Zero-cycle grant: a request is accepted in the same cycle as `*_addr_vld` when it is uncontested and `hready`=1.
- Response latency: the response appears on the first `hready`=1 cycle after acceptance, at the earliest 1 cycle.
- Back-to-back NONSEQ is supported; fetch and LSU transfers may pipeline alternately.
- Simultaneous requests:
  - The LSU is accepted first and fetch is stalled.
  - If `hready` is low while the LSU is presented, fetch cannot cut in (`aph_lock`).
- Reset mid-transfer:
  - `dph_owner` returns to NONE and the in-flight response is dropped.
  - The bus must be reset by the same `rst`.

## Configuration
- `HAZARD3_ARB_FAIRNESS_EN` defined:
  - A counter (4 bits) increments on each cycle with `f_addr_vld` & `l_addr_vld` & `l_addr_rdy`.
  - At `FETCH_STARVE_LIMIT`, `force_fetch`=1 and fetch wins the next unlocked arbitration.
  - The counter and `force_fetch` clear when `f_addr_rdy` & `f_addr_vld`.
- Undefined: strict LSU priority. The counter logic is absent and `force_fetch` is tied to 0.

## Test plan
- Fetch only, `hready`=1, `f_addr`=0x40 word: same-cycle `f_addr_rdy`, `haddr`=0x40, `hsize`=2, `hprot[0]`=0. Next cycle `f_data_vld`=1 with `f_data`=`hrdata`=0x12345678.
- Simultaneous fetch 0x80 and LSU write 0x2000, `hready`=1:
  - Cycle 0: LSU granted, `hwrite`=1, `hprot[0]`=1.
  - Cycle 1: fetch granted, `hwdata`=`l_wdata`=0xCAFEF00D.
  - Cycle 2: `f_data_vld`=1 and `l_data_vld`=0.
- Wait states: fetch presented with `hready`=0 for 3 cycles while the LSU asserts in cycle 1. `haddr` stays 0x80 and `l_addr_rdy`=0 until fetch is accepted.
- Error: LSU read with `hresp`=1, `hready`=0 then `hresp`=1, `hready`=1. `htrans`=IDLE in the first cycle; `l_data_err`=1 and `l_data_vld`=1 in the second; no `f_data_vld`.
- With `HAZARD3_ARB_FAIRNESS_EN`, limit 4, both requesting continuously: 4 LSU grants, then 1 fetch grant, then the LSU resumes. Without the macro, fetch is never granted.
- `rst` pulsed with `dph_owner`=FETCH: the next `hready`=1 cycle gives `f_data_vld`=0 and `htrans`=IDLE when no request is present.
